// File: rtl/line_mem_responder.sv
// Line memory responder: single-cycle read/write service with one-cycle response,
// write counting, and a sequential whole-array dump.
module line_mem_responder #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned LINES = 64,
    parameter int unsigned AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [AW-1:0]     req_addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              dump_start,
    input  logic              clr_count,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              wack,
    output logic              err,
    output logic              busy,
    output logic [WIDTH-1:0]  out_data,
    output logic [AW-1:0]     out_addr,
    output logic              out_valid,
    output logic              dump_done,
    output logic [AW:0]       wcount,
    output logic              all_written
);

    localparam logic [AW:0] LINES_V = (AW+1)'(LINES);
    localparam logic [AW:0] LAST_V  = (AW+1)'(LINES - 1);

    typedef enum logic [1:0] {IDLE, RESP, DUMP, FIN} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   mem [LINES];
    logic [AW:0]        ptr, ptr_d, ptr_nxt;
    logic [AW:0]        wcount_d;
    logic [WIDTH-1:0]   rdata_d, out_data_d;
    logic [AW-1:0]      out_addr_d;
    logic               rvalid_d, wack_d, err_d, out_valid_d, dump_done_d, busy_d;
    logic               addr_ok, we_c;

    assign addr_ok     = (AW+1)'(req_addr) < LINES_V;
    assign ptr_nxt     = ptr + (AW+1)'(1);
    assign all_written = (wcount == LINES_V);

    // Next state and next registered outputs
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        wcount_d    = wcount;
        rdata_d     = rdata;
        out_data_d  = out_data;
        out_addr_d  = out_addr;
        rvalid_d    = 1'b0;
        wack_d      = 1'b0;
        err_d       = 1'b0;
        out_valid_d = 1'b0;
        dump_done_d = 1'b0;
        we_c        = 1'b0;

        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_d     = DUMP;
                    ptr_d       = '0;
                    out_valid_d = 1'b1;
                    out_addr_d  = '0;
                    out_data_d  = mem[0];
                end else if (req_read || req_write) begin
                    state_d = RESP;
                    if (addr_ok) begin
                        if (req_write) begin
                            we_c   = 1'b1;
                            wack_d = 1'b1;
                            if (wcount != LINES_V) begin
                                wcount_d = wcount + (AW+1)'(1);
                            end
                        end
                        // Read sees the pre-write contents of the same edge
                        if (req_read) begin
                            rvalid_d = 1'b1;
                            rdata_d  = mem[req_addr];
                        end
                    end else begin
                        err_d = 1'b1;
                        if (req_read) begin
                            rvalid_d = 1'b1;
                            rdata_d  = '0;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DUMP: begin
                if (ptr == LAST_V) begin
                    state_d     = FIN;
                    dump_done_d = 1'b1;
                end else begin
                    ptr_d       = ptr_nxt;
                    out_valid_d = 1'b1;
                    out_addr_d  = ptr_nxt[AW-1:0];
                    out_data_d  = mem[ptr_nxt[AW-1:0]];
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_count) begin
            wcount_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            wcount    <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            wack      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            wcount    <= wcount_d;
            rdata     <= rdata_d;
            rvalid    <= rvalid_d;
            wack      <= wack_d;
            err       <= err_d;
            busy      <= busy_d;
            out_data  <= out_data_d;
            out_addr  <= out_addr_d;
            out_valid <= out_valid_d;
            dump_done <= dump_done_d;
        end
    end

    // Line storage, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LINES); i++) begin
                mem[i] <= '0;
            end
        end else if (we_c) begin
            mem[req_addr] <= wdata;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed testbench for line_mem_responder with hand-computed expectations.
module tb_line_mem_responder;

    logic        clk, rst;
    logic        req_read, req_write, dump_start, clr_count;
    logic [5:0]  req_addr;
    logic [24:0] wdata;
    logic [24:0] rdata, out_data;
    logic        rvalid, wack, err, busy, out_valid, dump_done, all_written;
    logic [5:0]  out_addr;
    logic [6:0]  wcount;

    int n_chk = 0;
    int n_err = 0;

    line_mem_responder dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .wdata(wdata), .dump_start(dump_start), .clr_count(clr_count),
        .rdata(rdata), .rvalid(rvalid), .wack(wack), .err(err), .busy(busy),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .dump_done(dump_done), .wcount(wcount), .all_written(all_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, 32'(rdata), 0);
        chk({tag, "_rvalid"}, 32'(rvalid), 0);
        chk({tag, "_wack"}, 32'(wack), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_addr"}, 32'(out_addr), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_dump_done"}, 32'(dump_done), 0);
        chk({tag, "_wcount"}, 32'(wcount), 0);
        chk({tag, "_all_written"}, 32'(all_written), 0);
    endtask

    // Present a request for one edge; returns mid-way through the response cycle
    task automatic req(input logic rd, input logic wr, input logic [5:0] a, input logic [24:0] d);
        @(negedge clk);
        req_read = rd; req_write = wr; req_addr = a; wdata = d;
        @(negedge clk);
        req_read = 1'b0; req_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_read = 0; req_write = 0; dump_start = 0; clr_count = 0;
        req_addr = '0; wdata = '0;
        @(negedge clk); @(negedge clk);
        chk_all_zero("por");
        rst = 1'b0;

        // 1. reset mid-simulation clears memory and counter
        req(0, 1, 6'd5, 25'h155);
        chk("t1_wcount_pre", 32'(wcount), 1);
        req(1, 0, 6'd5, '0);
        chk("t1_rdata_pre", 32'(rdata), 32'h155);
        @(negedge clk); #2 rst = 1'b1; #1;
        chk_all_zero("t1_rst");
        @(negedge clk); rst = 1'b0;
        req(1, 0, 6'd5, '0);
        chk("t1_rvalid", 32'(rvalid), 1);
        chk("t1_rdata", 32'(rdata), 0);
        chk("t1_err", 32'(err), 0);

        // 2. write then read, strobe during RESP ignored
        req(0, 1, 6'd3, 25'h1ABCDEF);
        chk("t2_wack", 32'(wack), 1);
        chk("t2_rvalid", 32'(rvalid), 0);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_wcount", 32'(wcount), 1);
        req_write = 1'b1; req_addr = 6'd4; wdata = 25'h5A5;
        @(negedge clk);
        req_write = 1'b0;
        chk("t2_ign_wack", 32'(wack), 0);
        chk("t2_ign_busy", 32'(busy), 0);
        chk("t2_ign_wcount", 32'(wcount), 1);
        req(1, 0, 6'd3, '0);
        chk("t2_rvalid", 32'(rvalid), 1);
        chk("t2_rdata", 32'(rdata), 32'h1ABCDEF);
        @(negedge clk);
        chk("t2_rvalid_drop", 32'(rvalid), 0);
        chk("t2_rdata_hold", 32'(rdata), 32'h1ABCDEF);
        req(1, 0, 6'd4, '0);
        chk("t2_ign_rdata", 32'(rdata), 0);

        // 3. simultaneous read and write to the same line
        req(0, 1, 6'd7, 25'h0000001);
        req(1, 1, 6'd7, 25'h0000002);
        chk("t3_rdata_old", 32'(rdata), 1);
        chk("t3_rvalid", 32'(rvalid), 1);
        chk("t3_wack", 32'(wack), 1);
        chk("t3_wcount", 32'(wcount), 3);
        req(1, 0, 6'd7, '0);
        chk("t3_rdata_new", 32'(rdata), 2);

        // 4. fill, saturate, clear (clear wins over a same-edge write)
        @(negedge clk); clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        chk("t4_clr0", 32'(wcount), 0);
        for (int i = 0; i < 64; i++) begin
            req(0, 1, 6'(i), 25'(i));
            if (i == 62) begin
                chk("t4_wcount63", 32'(wcount), 63);
                chk("t4_allw63", 32'(all_written), 0);
            end
        end
        chk("t4_wcount64", 32'(wcount), 64);
        chk("t4_allw", 32'(all_written), 1);
        req(0, 1, 6'd0, 25'd0);
        chk("t4_sat", 32'(wcount), 64);
        chk("t4_sat_wack", 32'(wack), 1);
        @(negedge clk);
        req_write = 1'b1; req_addr = 6'd1; wdata = 25'd1; clr_count = 1'b1;
        @(negedge clk);
        req_write = 1'b0; clr_count = 1'b0;
        chk("t4_clr_prio", 32'(wcount), 0);
        chk("t4_allw_clr", 32'(all_written), 0);

        // 5. full dump with ignored requests at start and mid-dump
        @(negedge clk);
        dump_start = 1'b1; req_write = 1'b1; req_addr = 6'd5; wdata = 25'h1FFFFFF;
        @(negedge clk);
        dump_start = 1'b0; req_write = 1'b0;
        for (int b = 0; b < 64; b++) begin
            chk("t5_valid", 32'(out_valid), 1);
            chk("t5_addr", 32'(out_addr), 32'(b));
            chk("t5_data", 32'(out_data), 32'(b));
            chk("t5_busy", 32'(busy), 1);
            if (b == 20) begin
                req_write = 1'b1; req_addr = 6'd9; wdata = 25'h777;
            end else begin
                req_write = 1'b0;
            end
            @(negedge clk);
        end
        req_write = 1'b0;
        chk("t5_fin_valid", 32'(out_valid), 0);
        chk("t5_fin_done", 32'(dump_done), 1);
        chk("t5_fin_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t5_done_drop", 32'(dump_done), 0);
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_wcount", 32'(wcount), 0);
        req(1, 0, 6'd5, '0);
        chk("t5_mem5", 32'(rdata), 5);
        req(1, 0, 6'd9, '0);
        chk("t5_mem9", 32'(rdata), 9);

        // 6. reset during the dump aborts it
        @(negedge clk); dump_start = 1'b1;
        @(negedge clk); dump_start = 1'b0;
        for (int b = 0; b < 10; b++) @(negedge clk);
        chk("t6_beat10", 32'(out_addr), 10);
        #1 rst = 1'b1; #1;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(dump_done), 0);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_no_beat", 32'(out_valid), 0);
            chk("t6_no_done", 32'(dump_done), 0);
        end
        req(1, 0, 6'd10, '0);
        chk("t6_rvalid", 32'(rvalid), 1);
        chk("t6_rdata", 32'(rdata), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
